// File: rtl/npc_unit_pkg.sv
// Shared pipeline definitions for the next-PC logic: select encodings and reset vector.
package npc_unit_pkg;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;

    // Branch/jump displacement: word offset sign-extended and scaled to bytes.
    function automatic logic [31:0] br_disp(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/npc_unit_calc.sv
// Combinational next-PC computation: sequential, branch, 26-bit jump and register-jump targets.
module npc_calc
    import npc_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [31:0] pc_d,
    input  logic [25:0] instr_index,
    input  logic [15:0] offset,
    input  logic [31:0] reg_target,
    input  logic        judge,
    output logic [31:0] npc
);

    logic [31:0] seq_pc;
    logic [31:0] pc_d4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Target candidates; jump region bits come from the delay-slot address pc_d + 4.
    always_comb begin
        seq_pc    = pc + 32'd4;
        pc_d4     = pc_d + 32'd4;
        br_target = pc_d4 + br_disp(offset);
        j_target  = {pc_d4[31:28], instr_index, 2'b00};
    end

    // Next-PC select; judge only matters for a branch.
    always_comb begin
        npc = seq_pc;
        case (npc_op_e'(npc_op))
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = judge ? br_target : seq_pc;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = reg_target;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/npc_unit.sv
// Fetch-stage next-PC unit: owns the fetch PC register and wraps the target calculator.
module npc_unit
    import npc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic [1:0]  npc_op,
    input  logic [31:0] pc_d,
    input  logic [25:0] instr_index,
    input  logic [15:0] offset,
    input  logic [31:0] reg_target,
    input  logic        judge,
    output logic [31:0] pc,
    output logic [31:0] npc
);

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;

    npc_calc u_calc (
        .pc          (fetch_pc_q),
        .npc_op      (npc_op),
        .pc_d        (pc_d),
        .instr_index (instr_index),
        .offset      (offset),
        .reg_target  (reg_target),
        .judge       (judge),
        .npc         (npc)
    );

    // Load the computed next PC unless the pipeline is stalled.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (pc_write) begin
            fetch_pc_d = npc;
        end
    end

    // Fetch PC register; active-low asynchronous reset to the reset vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign pc = fetch_pc_q;

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: directed cases plus randomized cycles against a behavioural model.
module tb_npc_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic [1:0]  npc_op;
    logic [31:0] pc_d;
    logic [25:0] instr_index;
    logic [15:0] offset;
    logic [31:0] reg_target;
    logic        judge;
    logic [31:0] pc;
    logic [31:0] npc;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] mpc;

    npc_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_write    (pc_write),
        .npc_op      (npc_op),
        .pc_d        (pc_d),
        .instr_index (instr_index),
        .offset      (offset),
        .reg_target  (reg_target),
        .judge       (judge),
        .pc          (pc),
        .npc         (npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next PC from the architectural rules, using signed integer arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                            input logic [31:0] dpc, input logic [25:0] idx,
                                            input logic [15:0] off, input logic [31:0] rt,
                                            input logic jg);
        logic signed [15:0] soff;
        longint             t;
        logic [31:0]        slot;
        soff = off;
        slot = dpc + 32'd4;
        case (op)
            2'd0: t = longint'(cur) + 4;
            2'd1: t = jg ? longint'(slot) + longint'(soff) * 4 : longint'(cur) + 4;
            2'd2: t = longint'(slot / 32'h1000_0000) * 64'h1000_0000 + longint'(idx) * 4;
            default: t = longint'(rt);
        endcase
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] dpc, input logic [25:0] idx,
                         input logic [15:0] off, input logic [31:0] rt, input logic jg);
        npc_op      = op;
        pc_d        = dpc;
        instr_index = idx;
        offset      = off;
        reg_target  = rt;
        judge       = jg;
    endtask

    initial begin
        reset    = 1'b1;
        pc_write = 1'b1;
        drive(2'd0, '0, '0, '0, '0, 1'b0);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        chk("reset_async", pc, 32'h0000_3000);
        // Reset held across an edge with a jump pending: reset wins
        drive(2'd2, 32'h0000_3020, 26'h0000C10, '0, '0, 1'b0);
        tick;
        chk("reset_hold", pc, 32'h0000_3000);
        drive(2'd0, '0, '0, '0, '0, 1'b0);
        #2;
        reset = 1'b1;
        tick;
        chk("seq1", pc, 32'h0000_3004);
        tick;
        chk("seq2", pc, 32'h0000_3008);
        tick;
        chk("seq3", pc, 32'h0000_300C);
        tick;
        chk("seq4", pc, 32'h0000_3010);

        // Branch taken / not taken from pc = 3010, pc_d = 300C
        drive(2'd1, 32'h0000_300C, '0, 16'hFFFD, '0, 1'b1);
        #1;
        chk("br_taken", npc, 32'h0000_3004);
        judge = 1'b0;
        #1;
        chk("br_not_taken", npc, 32'h0000_3014);
        tick;
        chk("br_nt_load", pc, 32'h0000_3014);

        // Maximum negative offset
        drive(2'd1, 32'h0000_3000, '0, 16'h8000, '0, 1'b1);
        #1;
        chk("br_maxneg", npc, 32'hFFFE_3004);

        // Jump, including region from pc_d + 4 across a 256 MB boundary
        drive(2'd2, 32'h0FFF_FFFC, 26'h0000000, '0, '0, 1'b1);
        #1;
        chk("j_region", npc, 32'h1000_0000);
        drive(2'd2, 32'h0000_3020, 26'h0000C10, '0, '0, 1'b0);
        #1;
        chk("j_target", npc, 32'h0000_3040);
        tick;
        chk("j_load", pc, 32'h0000_3040);

        // Jump-register, unmasked, judge ignored
        drive(2'd3, '0, '0, '0, 32'h0000_4002, 1'b1);
        #1;
        chk("jr_target", npc, 32'h0000_4002);

        // Stall two edges with a jump selected
        drive(2'd2, 32'h0000_5000, 26'h0001000, '0, '0, 1'b0);
        pc_write = 1'b0;
        tick;
        chk("stall1", pc, 32'h0000_3040);
        tick;
        chk("stall2", pc, 32'h0000_3040);
        pc_write = 1'b1;
        tick;
        chk("stall_release", pc, 32'h0000_4000);

        // Wrap-around
        drive(2'd3, '0, '0, '0, 32'hFFFF_FFFC, 1'b0);
        tick;
        chk("wrap_setup", pc, 32'hFFFF_FFFC);
        drive(2'd0, '0, '0, '0, '0, 1'b1);
        #1;
        chk("wrap_npc", npc, 32'h0000_0000);
        tick;
        chk("wrap_pc", pc, 32'h0000_0000);

        // Randomized cycles against the model
        mpc = 32'h0000_0000;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] off;
            off = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
            drive(2'($urandom), $urandom, 26'($urandom), off, $urandom, 1'($urandom));
            pc_write = ($urandom_range(0, 3) != 0);
            #1;
            chk("rand_npc", npc, ref_npc(mpc, npc_op, pc_d, instr_index, offset, reg_target, judge));
            if (pc_write) begin
                mpc = ref_npc(mpc, npc_op, pc_d, instr_index, offset, reg_target, judge);
            end
            tick;
            chk("rand_pc", pc, mpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
# npc_unit

Next-PC unit of the five-stage MIPS pipeline, sitting in the fetch stage beside instruction memory. It owns the fetch PC register and computes the next fetch address each cycle. The next address is chosen from sequential increment, conditional branch, 26-bit jump, or register jump. Branch and jump targets are resolved in decode from the decode-stage PC, with the delay-slot convention.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value loaded into the PC on reset.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset of the PC register.
- pc_write, input, 1: PC update enable; 0 = stall (hold PC).
- npc_op, input, 2: next-PC select. 00 = seq, 01 = branch, 10 = jump, 11 = jump-register.
- pc_d, input, 32: PC of the instruction in decode (branch/jump owner).
- instr_index, input, 26: jump target field.
- offset, input, 16: branch offset field.
- reg_target, input, 32: forwarded rs value for jump-register.
- judge, input, 1: branch condition true (valid only when npc_op = 01).
- pc, output, 32: current fetch PC (registered).
- npc, output, 32: next PC (combinational).

## Operation
- seq_pc = pc + 4, modulo 2^32.
- br_target = pc_d + 4 + (sign_extend(offset) << 2), modulo 2^32.
- j_target = {pc_d[31:28], instr_index, 2'b00}. Upper bits come from pc_d + 4; they equal pc_d[31:28] except when crossing a 256 MB boundary, and the pc_d + 4 bits are authoritative.
- npc selection:
  - 00: seq_pc.
  - 01: br_target if judge = 1, else seq_pc.
  - 10: j_target.
  - 11: reg_target, passed through unmodified (no alignment masking).
- judge is ignored for every npc_op other than 01.
- Not-taken branch uses seq_pc of the fetch PC, because the delay slot has already been fetched.

## Timing
- npc is purely combinational from pc and all data inputs; it settles within the same cycle.
- On the rising clk edge with reset = 1 and pc_write = 1: pc <= npc.
- With pc_write = 0: pc holds its value, whatever npc_op is.
- reset = 0 forces pc = RESET_PC immediately, independent of clk. pc stays at RESET_PC while reset is low.
- On reset release, the first edge with pc_write = 1 loads npc computed from RESET_PC.
- Reset asserted mid-redirect (e.g. npc_op = 10 that cycle) wins; no pending target is remembered.
- Wrap-around: pc = 32'hFFFF_FFFC with npc_op = 00 gives npc = 32'h0000_0000.
- Maximum negative offset (16'h8000) subtracts 0x20000 from pc_d + 4, using two's-complement wrap.

## Structure
- Shared pipeline package holds:
  - npc_op encodings: NPC_SEQ = 2'b00, NPC_BR = 2'b01, NPC_J = 2'b10, NPC_JR = 2'b11.
  - the reset-vector constant 32'h0000_3000.
- One natural sub-module: npc_calc, holding the combinational target computation and mux. npc_unit wraps npc_calc together with the PC register.
- No other state.

## Test plan
- Reset behaviour: assert reset low asynchronously mid-cycle -> pc = 32'h0000_3000 immediately. Release, then npc_op = 00 for 3 edges -> pc = 3004, 3008, 300C.
- Branch taken and not-taken, with pc = 32'h3010, pc_d = 32'h300C, offset = 16'hFFFD, npc_op = 01:
  - judge = 1 -> npc = 32'h0000_3004.
  - judge = 0 -> npc = 32'h0000_3014.
- Jump: pc_d = 32'h0000_3020, instr_index = 26'h0000C10, npc_op = 10 -> npc = 32'h0000_3040; pc loads it on the next edge.
- Jump-register: reg_target = 32'h0000_4002, npc_op = 11 -> npc = 32'h0000_4002, unmasked. judge = 1 has no effect.
- Stall: pc_write = 0 for 2 edges with npc_op = 10 -> pc unchanged. pc_write = 1 -> pc = j_target.
- Wrap: pc forced to 32'hFFFF_FFFC via branch/jump-register, then npc_op = 00 -> next pc = 32'h0000_0000.
